// File: rtl/qdma_h2c_axis_sink.sv
// qdma_h2c_axis_sink
// Consumer and checker for the QDMA H2C AXI-Stream. Accepts 512-bit beats,
// optionally throttles tready with a periodic gap, checks byte parity, tkeep
// shape and tusr stability, and reports length, qid and error flags for
// every completed packet along with running packet and error counters.

module qdma_h2c_axis_sink #(
  parameter int BP_PERIOD = 4
) (
  input  logic         user_clk,
  input  logic         user_reset,
  input  logic [511:0] s_axis_h2c_tdata,
  input  logic [63:0]  s_axis_h2c_tparity,
  input  logic         s_axis_h2c_tlast,
  input  logic         s_axis_h2c_tvalid,
  input  logic [63:0]  s_axis_h2c_tkeep,
  input  logic [63:0]  s_axis_h2c_tusr,
  output logic         s_axis_h2c_tready,
  input  logic         bp_en,
  output logic         pkt_done,
  output logic [10:0]  pkt_qid,
  output logic [15:0]  pkt_len,
  output logic [3:0]   pkt_err,
  output logic [31:0]  pkt_cnt,
  output logic [31:0]  err_cnt
);

  // Packet FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  // Counter value at which tready is dropped while backpressure is enabled
  localparam logic [3:0] BP_LAST = 4'(BP_PERIOD - 1);

  // Largest value the 17-bit length accumulator is allowed to hold
  localparam logic [17:0] LEN_CLAMP = 18'h10000;

  logic [0:0]  state;
  logic [26:0] cap_tusr;
  logic [16:0] len_acc;
  logic [3:0]  err_acc;
  logic [3:0]  bp_cnt;
  logic [3:0]  bp_cnt_next;
  logic        tready_q;

  logic        beat_ok;
  logic        is_first;
  logic [26:0] tusr_ref;
  logic        par_bad;
  logic [63:0] keep_plus1;
  logic        keep_contig;
  logic        keep_bad;
  logic [6:0]  keep_pop;
  logic [6:0]  beat_bytes;
  logic [16:0] len_base;
  logic [17:0] len_sum;
  logic [16:0] len_next;
  logic        len_ovf;
  logic        len_mismatch;
  logic        tusr_bad;
  logic [3:0]  err_base;
  logic [3:0]  err_next;
  logic [3:0]  err_final;
  logic [15:0] pkt_len_next;

  // Only qid and expected length are meaningful in tusr
  logic unused_tusr_hi;
  assign unused_tusr_hi = ^s_axis_h2c_tusr[63:27];

  assign s_axis_h2c_tready = tready_q;

  // Beat handshake and selection of the reference tusr for this beat
  always_comb begin
    beat_ok  = s_axis_h2c_tvalid & tready_q;
    is_first = (state == ST_IDLE);
    tusr_ref = is_first ? s_axis_h2c_tusr[26:0] : cap_tusr;
    tusr_bad = !is_first && (s_axis_h2c_tusr[26:0] != cap_tusr);
  end

  // Even-parity check over the kept bytes only
  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (s_axis_h2c_tkeep[i] && (s_axis_h2c_tparity[i] != ^s_axis_h2c_tdata[8*i +: 8])) begin
        par_bad = 1'b1;
      end
    end
  end

  // Byte count of the beat's tkeep, used for the trailing beat length
  always_comb begin
    keep_pop = 7'd0;
    for (int i = 0; i < 64; i++) begin
      keep_pop = keep_pop + {6'd0, s_axis_h2c_tkeep[i]};
    end
  end

  // Keep shape: full on body beats, nonzero 2^n-1 mask on the last beat
  always_comb begin
    keep_plus1  = s_axis_h2c_tkeep + 64'd1;
    keep_contig = ((s_axis_h2c_tkeep & keep_plus1) == 64'd0);
    if (s_axis_h2c_tlast) begin
      keep_bad = (s_axis_h2c_tkeep == 64'd0) || !keep_contig;
    end else begin
      keep_bad = (s_axis_h2c_tkeep != {64{1'b1}});
    end
  end

  // Length accumulation with clamping so an oversize packet stays flagged
  always_comb begin
    beat_bytes = s_axis_h2c_tlast ? keep_pop : 7'd64;
    len_base   = is_first ? 17'd0 : len_acc;
    len_sum    = {1'b0, len_base} + {11'd0, beat_bytes};
    if (len_sum > LEN_CLAMP) begin
      len_next = LEN_CLAMP[16:0];
    end else begin
      len_next = len_sum[16:0];
    end
    len_ovf      = len_next[16];
    len_mismatch = (len_next != {1'b0, tusr_ref[26:11]});
    pkt_len_next = len_ovf ? 16'hFFFF : len_next[15:0];
  end

  // Error flag merge; a first beat starts from a clean slate
  always_comb begin
    err_base  = is_first ? 4'd0 : err_acc;
    err_next  = err_base | {tusr_bad, len_ovf, keep_bad, par_bad};
    err_final = err_next | {1'b0, len_mismatch, 2'b00};
  end

  // Free-running backpressure phase counter
  always_comb begin
    if (bp_cnt == BP_LAST) begin
      bp_cnt_next = 4'd0;
    end else begin
      bp_cnt_next = bp_cnt + 4'd1;
    end
  end

  // Registered tready: low during the last phase of each period when enabled
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      bp_cnt   <= 4'd0;
      tready_q <= 1'b0;
    end else begin
      bp_cnt   <= bp_cnt_next;
      tready_q <= !(bp_en && (bp_cnt_next == BP_LAST));
    end
  end

  // Packet FSM and per-packet accumulators
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state    <= ST_IDLE;
      cap_tusr <= 27'd0;
      len_acc  <= 17'd0;
      err_acc  <= 4'd0;
    end else if (beat_ok) begin
      if (s_axis_h2c_tlast) begin
        state    <= ST_IDLE;
        cap_tusr <= 27'd0;
        len_acc  <= 17'd0;
        err_acc  <= 4'd0;
      end else begin
        state    <= ST_BODY;
        cap_tusr <= tusr_ref;
        len_acc  <= len_next;
        err_acc  <= err_next;
      end
    end
  end

  // Completion report, held until the next packet completes
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      pkt_done <= 1'b0;
      pkt_qid  <= 11'd0;
      pkt_len  <= 16'd0;
      pkt_err  <= 4'd0;
    end else if (beat_ok && s_axis_h2c_tlast) begin
      pkt_done <= 1'b1;
      pkt_qid  <= tusr_ref[10:0];
      pkt_len  <= pkt_len_next;
      pkt_err  <= err_final;
    end else begin
      pkt_done <= 1'b0;
    end
  end

  // Running packet and errored-packet counters, wrapping at 2^32
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      pkt_cnt <= 32'd0;
      err_cnt <= 32'd0;
    end else if (beat_ok && s_axis_h2c_tlast) begin
      pkt_cnt <= pkt_cnt + 32'd1;
      if (err_final != 4'd0) begin
        err_cnt <= err_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_qdma_h2c_axis_sink.sv
// tb_qdma_h2c_axis_sink
// Directed bench for the H2C stream sink: reset values, packet reporting,
// back-to-back packets, parity/keep/length/tusr errors, backpressure and
// reset in the middle of a packet.

module tb_qdma_h2c_axis_sink;

  logic         user_clk;
  logic         user_reset;
  logic [511:0] s_axis_h2c_tdata;
  logic [63:0]  s_axis_h2c_tparity;
  logic         s_axis_h2c_tlast;
  logic         s_axis_h2c_tvalid;
  logic [63:0]  s_axis_h2c_tkeep;
  logic [63:0]  s_axis_h2c_tusr;
  logic         s_axis_h2c_tready;
  logic         bp_en;
  logic         pkt_done;
  logic [10:0]  pkt_qid;
  logic [15:0]  pkt_len;
  logic [3:0]   pkt_err;
  logic [31:0]  pkt_cnt;
  logic [31:0]  err_cnt;

  localparam logic [63:0] KEEP_FULL = {64{1'b1}};
  localparam logic [63:0] KEEP_36   = 64'h0000_000F_FFFF_FFFF;

  int errors = 0;
  int checks = 0;
  int exp_pkt_cnt = 0;
  int exp_err_cnt = 0;
  int cycle_no = 0;
  int total_cycles = 0;
  int last_cycles = 0;
  int done_pulses = 0;
  int low_q[$];

  qdma_h2c_axis_sink #(.BP_PERIOD(4)) dut (
    .user_clk           (user_clk),
    .user_reset         (user_reset),
    .s_axis_h2c_tdata   (s_axis_h2c_tdata),
    .s_axis_h2c_tparity (s_axis_h2c_tparity),
    .s_axis_h2c_tlast   (s_axis_h2c_tlast),
    .s_axis_h2c_tvalid  (s_axis_h2c_tvalid),
    .s_axis_h2c_tkeep   (s_axis_h2c_tkeep),
    .s_axis_h2c_tusr    (s_axis_h2c_tusr),
    .s_axis_h2c_tready  (s_axis_h2c_tready),
    .bp_en              (bp_en),
    .pkt_done           (pkt_done),
    .pkt_qid            (pkt_qid),
    .pkt_len            (pkt_len),
    .pkt_err            (pkt_err),
    .pkt_cnt            (pkt_cnt),
    .err_cnt            (err_cnt)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  always @(posedge user_clk) cycle_no++;
  always @(negedge user_clk) if (pkt_done === 1'b1) done_pulses++;

  function automatic logic [63:0] mk_tusr(input logic [15:0] len, input logic [10:0] qid);
    mk_tusr = {37'd0, len, qid};
  endfunction

  function automatic logic [511:0] mk_data(input int seed);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(seed * 31 + i * 7 + 1);
    mk_data = d;
  endfunction

  function automatic logic [63:0] gen_parity(input logic [511:0] d);
    logic [63:0] p;
    for (int i = 0; i < 64; i++) p[i] = ^d[8*i +: 8];
    gen_parity = p;
  endfunction

  // Present one beat and hold it until accepted (bounded)
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                           input logic [63:0] u, input logic [63:0] flip);
    logic acc;
    logic done;
    int n;
    s_axis_h2c_tdata   = d;
    s_axis_h2c_tkeep   = k;
    s_axis_h2c_tlast   = l;
    s_axis_h2c_tusr    = u;
    s_axis_h2c_tparity = gen_parity(d) ^ flip;
    s_axis_h2c_tvalid  = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      acc = s_axis_h2c_tready;
      if (!acc) low_q.push_back(cycle_no);
      @(posedge user_clk);
      #1;
      n++;
      total_cycles++;
      done = acc;
    end
    last_cycles = n;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL beat_accept_timeout: accepted=%0b required=1", done);
    end
  endtask

  task automatic idle_cycles(input int n);
    s_axis_h2c_tvalid = 1'b0;
    s_axis_h2c_tlast  = 1'b0;
    repeat (n) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    user_reset = 1'b1;
    bp_en = 1'b0;
    s_axis_h2c_tvalid = 1'b0;
    s_axis_h2c_tlast = 1'b0;
    s_axis_h2c_tdata = '0;
    s_axis_h2c_tkeep = '0;
    s_axis_h2c_tusr = '0;
    s_axis_h2c_tparity = '0;
    repeat (3) @(posedge user_clk);
    #1;
    checks++; if (s_axis_h2c_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_tready: got %0b want 0", s_axis_h2c_tready); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b want 0", pkt_done); end
    checks++; if (pkt_qid !== 11'd0) begin errors++; $display("[TB] FAIL reset_qid: got %0h want 0", pkt_qid); end
    checks++; if (pkt_len !== 16'd0) begin errors++; $display("[TB] FAIL reset_len: got %0h want 0", pkt_len); end
    checks++; if (pkt_err !== 4'd0) begin errors++; $display("[TB] FAIL reset_err: got %0h want 0", pkt_err); end
    checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
    checks++; if (err_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    user_reset = 1'b0;
    @(posedge user_clk);
    #1;
    checks++; if (s_axis_h2c_tready !== 1'b1) begin errors++; $display("[TB] FAIL tready_after_reset: got %0b want 1", s_axis_h2c_tready); end
  endtask

  task automatic test_single_packet();
    $display("[TB] test_single_packet");
    send_beat(mk_data(1), KEEP_FULL, 1'b0, mk_tusr(16'd100, 11'd5), 64'd0);
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("[TB] FAIL single_early_done: got %0b want 0", pkt_done); end
    send_beat(mk_data(2), KEEP_36, 1'b1, mk_tusr(16'd100, 11'd5), 64'd0);
    exp_pkt_cnt++;
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("[TB] FAIL single_done: got %0b want 1", pkt_done); end
    checks++; if (pkt_len !== 16'd100) begin errors++; $display("[TB] FAIL single_len: got %0d want 100", pkt_len); end
    checks++; if (pkt_qid !== 11'd5) begin errors++; $display("[TB] FAIL single_qid: got %0d want 5", pkt_qid); end
    checks++; if (pkt_err !== 4'd0) begin errors++; $display("[TB] FAIL single_err: got %0h want 0", pkt_err); end
    checks++; if (pkt_cnt !== 32'(exp_pkt_cnt)) begin errors++; $display("[TB] FAIL single_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt_cnt); end
    idle_cycles(1);
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_pulse: got %0b want 0", pkt_done); end
    checks++; if (pkt_len !== 16'd100) begin errors++; $display("[TB] FAIL single_len_hold: got %0d want 100", pkt_len); end
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    send_beat(mk_data(3), KEEP_FULL, 1'b1, mk_tusr(16'd64, 11'd1), 64'd0);
    exp_pkt_cnt++;
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done1: got %0b want 1", pkt_done); end
    checks++; if (pkt_qid !== 11'd1) begin errors++; $display("[TB] FAIL b2b_qid1: got %0d want 1", pkt_qid); end
    send_beat(mk_data(4), KEEP_FULL, 1'b1, mk_tusr(16'd64, 11'd2), 64'd0);
    exp_pkt_cnt++;
    checks++; if (last_cycles !== 1) begin errors++; $display("[TB] FAIL b2b_cycles: got %0d want 1", last_cycles); end
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done2: got %0b want 1", pkt_done); end
    checks++; if (pkt_qid !== 11'd2) begin errors++; $display("[TB] FAIL b2b_qid2: got %0d want 2", pkt_qid); end
    checks++; if (pkt_len !== 16'd64) begin errors++; $display("[TB] FAIL b2b_len2: got %0d want 64", pkt_len); end
    checks++; if (pkt_err !== 4'd0) begin errors++; $display("[TB] FAIL b2b_err2: got %0h want 0", pkt_err); end
    checks++; if (pkt_cnt !== 32'(exp_pkt_cnt)) begin errors++; $display("[TB] FAIL b2b_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt_cnt); end
    idle_cycles(1);
  endtask

  task automatic test_parity();
    $display("[TB] test_parity");
    send_beat(mk_data(5), KEEP_FULL, 1'b0, mk_tusr(16'd128, 11'd6), 64'h8);
    send_beat(mk_data(6), KEEP_FULL, 1'b1, mk_tusr(16'd128, 11'd6), 64'd0);
    exp_pkt_cnt++; exp_err_cnt++;
    checks++; if (pkt_err !== 4'b0001) begin errors++; $display("[TB] FAIL parity_err: got %b want 0001", pkt_err); end
    checks++; if (err_cnt !== 32'(exp_err_cnt)) begin errors++; $display("[TB] FAIL parity_err_cnt: got %0d want %0d", err_cnt, exp_err_cnt); end
    send_beat(mk_data(7), KEEP_FULL, 1'b0, mk_tusr(16'd100, 11'd6), 64'd0);
    send_beat(mk_data(8), KEEP_36, 1'b1, mk_tusr(16'd100, 11'd6), 64'h0004_0000_0000_0000);
    exp_pkt_cnt++;
    checks++; if (pkt_err !== 4'b0000) begin errors++; $display("[TB] FAIL parity_unkept_err: got %b want 0000", pkt_err); end
    checks++; if (err_cnt !== 32'(exp_err_cnt)) begin errors++; $display("[TB] FAIL parity_unkept_err_cnt: got %0d want %0d", err_cnt, exp_err_cnt); end
    idle_cycles(1);
  endtask

  task automatic test_keep();
    $display("[TB] test_keep");
    send_beat(mk_data(9), 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, mk_tusr(16'd128, 11'd10), 64'd0);
    send_beat(mk_data(10), KEEP_FULL, 1'b1, mk_tusr(16'd128, 11'd10), 64'd0);
    exp_pkt_cnt++; exp_err_cnt++;
    checks++; if (pkt_err !== 4'b0010) begin errors++; $display("[TB] FAIL keep_body_err: got %b want 0010", pkt_err); end
    checks++; if (pkt_len !== 16'd128) begin errors++; $display("[TB] FAIL keep_body_len: got %0d want 128", pkt_len); end
    send_beat(mk_data(11), 64'h0F0, 1'b1, mk_tusr(16'd4, 11'd11), 64'd0);
    exp_pkt_cnt++; exp_err_cnt++;
    checks++; if (pkt_err !== 4'b0010) begin errors++; $display("[TB] FAIL keep_last_err: got %b want 0010", pkt_err); end
    checks++; if (pkt_len !== 16'd4) begin errors++; $display("[TB] FAIL keep_last_len: got %0d want 4", pkt_len); end
    checks++; if (err_cnt !== 32'(exp_err_cnt)) begin errors++; $display("[TB] FAIL keep_err_cnt: got %0d want %0d", err_cnt, exp_err_cnt); end
    idle_cycles(1);
  endtask

  task automatic test_length_and_tusr();
    $display("[TB] test_length_and_tusr");
    send_beat(mk_data(12), KEEP_FULL, 1'b1, mk_tusr(16'd60, 11'd3), 64'd0);
    exp_pkt_cnt++; exp_err_cnt++;
    checks++; if (pkt_err !== 4'b0100) begin errors++; $display("[TB] FAIL len_mismatch_err: got %b want 0100", pkt_err); end
    checks++; if (pkt_len !== 16'd64) begin errors++; $display("[TB] FAIL len_mismatch_len: got %0d want 64", pkt_len); end
    send_beat(mk_data(13), KEEP_FULL, 1'b0, mk_tusr(16'd128, 11'd7), 64'd0);
    send_beat(mk_data(14), KEEP_FULL, 1'b1, mk_tusr(16'd128, 11'd8), 64'd0);
    exp_pkt_cnt++; exp_err_cnt++;
    checks++; if (pkt_err !== 4'b1000) begin errors++; $display("[TB] FAIL tusr_change_err: got %b want 1000", pkt_err); end
    checks++; if (pkt_qid !== 11'd7) begin errors++; $display("[TB] FAIL tusr_change_qid: got %0d want 7", pkt_qid); end
    checks++; if (pkt_cnt !== 32'(exp_pkt_cnt)) begin errors++; $display("[TB] FAIL tusr_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt_cnt); end
    checks++; if (err_cnt !== 32'(exp_err_cnt)) begin errors++; $display("[TB] FAIL tusr_err_cnt: got %0d want %0d", err_cnt, exp_err_cnt); end
    idle_cycles(1);
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    bp_en = 1'b1;
    idle_cycles(6);
    low_q.delete();
    total_cycles = 0;
    for (int b = 0; b < 8; b++) begin
      send_beat(mk_data(20 + b), KEEP_FULL, (b == 7), mk_tusr(16'd512, 11'd9), 64'd0);
    end
    exp_pkt_cnt++;
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("[TB] FAIL bp_done: got %0b want 1", pkt_done); end
    checks++; if (pkt_len !== 16'd512) begin errors++; $display("[TB] FAIL bp_len: got %0d want 512", pkt_len); end
    checks++; if (pkt_err !== 4'd0) begin errors++; $display("[TB] FAIL bp_err: got %b want 0000", pkt_err); end
    checks++; if (total_cycles < 10 || total_cycles > 11) begin errors++; $display("[TB] FAIL bp_cycles: got %0d want 10..11", total_cycles); end
    checks++; if (low_q.size() < 2) begin errors++; $display("[TB] FAIL bp_low_count: got %0d want >=2", low_q.size()); end
    for (int i = 1; i < low_q.size(); i++) begin
      checks++;
      if (low_q[i] - low_q[i-1] !== 4) begin
        errors++;
        $display("[TB] FAIL bp_gap: got %0d want 4", low_q[i] - low_q[i-1]);
      end
    end
    bp_en = 1'b0;
    idle_cycles(2);
    checks++; if (s_axis_h2c_tready !== 1'b1) begin errors++; $display("[TB] FAIL bp_off_tready: got %0b want 1", s_axis_h2c_tready); end
  endtask

  task automatic test_reset_abort();
    int pulses_before;
    $display("[TB] test_reset_abort");
    for (int b = 0; b < 3; b++) begin
      send_beat(mk_data(40 + b), KEEP_FULL, 1'b0, mk_tusr(16'd384, 11'd3), 64'd0);
    end
    pulses_before = done_pulses;
    s_axis_h2c_tvalid = 1'b0;
    user_reset = 1'b1;
    repeat (2) @(posedge user_clk);
    #1;
    checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("[TB] FAIL abort_pkt_cnt: got %0d want 0", pkt_cnt); end
    checks++; if (s_axis_h2c_tready !== 1'b0) begin errors++; $display("[TB] FAIL abort_tready: got %0b want 0", s_axis_h2c_tready); end
    user_reset = 1'b0;
    exp_pkt_cnt = 0;
    exp_err_cnt = 0;
    idle_cycles(1);
    send_beat(mk_data(50), KEEP_FULL, 1'b1, mk_tusr(16'd64, 11'd12), 64'd0);
    exp_pkt_cnt++;
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("[TB] FAIL abort_new_done: got %0b want 1", pkt_done); end
    checks++; if (pkt_len !== 16'd64) begin errors++; $display("[TB] FAIL abort_new_len: got %0d want 64", pkt_len); end
    checks++; if (pkt_err !== 4'd0) begin errors++; $display("[TB] FAIL abort_new_err: got %b want 0000", pkt_err); end
    checks++; if (pkt_qid !== 11'd12) begin errors++; $display("[TB] FAIL abort_new_qid: got %0d want 12", pkt_qid); end
    checks++; if (pkt_cnt !== 32'(exp_pkt_cnt)) begin errors++; $display("[TB] FAIL abort_new_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt_cnt); end
    idle_cycles(1);
    checks++; if (done_pulses - pulses_before !== 1) begin errors++; $display("[TB] FAIL abort_pulses: got %0d want 1", done_pulses - pulses_before); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_parity();
    test_keep();
    test_length_and_tusr();
    test_backpressure();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
